// File: rtl/lsu_mem_access.sv
// lsu_mem_access: load/store unit sitting behind a word-only synchronous data RAM.
//   Loads:  read the word, select the byte/half lane and sign/zero-extend it.
//   Stores: word stores write directly; byte/half stores read-modify-write.
//   Misaligned accesses are suppressed and flagged with a one-cycle pulse.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   req_read, req_write        load / store request (store wins if both high)
//   operation_byte_size        store size: 00 byte, 01 half, 11 word
//   MemResultCtr               load type: 001 LB, 010 LH, 100 LBU, 101 LHU, else word
//   addr, wdata                byte address and store data
//   stall                      hold the pipeline while the access is in flight
//   done, rdata, misaligned    completion pulse, extended load data, alignment error
//   mem_*                      synchronous RAM port (read data one cycle after enable)
module lsu_mem_access #(
    parameter int unsigned MEM_AW = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_read,
    input  logic              req_write,
    input  logic [1:0]        operation_byte_size,
    input  logic [2:0]        MemResultCtr,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              misaligned,
    output logic              mem_en,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [2:0] {StIdle, StRdIssue, StRdWait, StWrite, StDone} state_e;

    localparam logic [1:0] SzByte = 2'd0;
    localparam logic [1:0] SzHalf = 2'd1;
    localparam logic [1:0] SzWord = 2'd2;

    state_e              state_q, state_d;
    logic [MEM_AW-1:0]   waddr_q, waddr_d;
    logic [1:0]          lane_q, lane_d;
    logic [1:0]          size_q, size_d;
    logic [2:0]          ctr_q, ctr_d;
    logic                store_q, store_d;
    logic                misal_q, misal_d;
    // Holds the store data until RD_WAIT, then the merged word to be written.
    logic [31:0]         data_q, data_d;
    logic [31:0]         rdata_q, rdata_d;

    logic [1:0]          req_size;
    logic                req_misal;
    logic [7:0]          byte_v;
    logic [15:0]         half_v;
    logic [31:0]         load_ext;
    logic [31:0]         merged;

    // Upper address bits wrap by design.
    logic unused_addr;
    assign unused_addr = ^addr[31:MEM_AW+2];

    // Access size and alignment of the incoming request.
    always_comb begin
        req_size = SzWord;
        if (req_write) begin
            unique case (operation_byte_size)
                2'b00:   req_size = SzByte;
                2'b01:   req_size = SzHalf;
                default: req_size = SzWord;
            endcase
        end else begin
            unique case (MemResultCtr)
                3'b001, 3'b100: req_size = SzByte;
                3'b010, 3'b101: req_size = SzHalf;
                default:        req_size = SzWord;
            endcase
        end
        req_misal = ((req_size == SzHalf) && addr[0]) ||
                    ((req_size == SzWord) && (addr[1:0] != 2'b00));
    end

    // Lane extraction and merge against the word returned by the RAM.
    always_comb begin
        byte_v = mem_rdata[{lane_q, 3'b000} +: 8];
        half_v = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        unique case (ctr_q)
            3'b001:  load_ext = {{24{byte_v[7]}}, byte_v};
            3'b100:  load_ext = {24'd0, byte_v};
            3'b010:  load_ext = {{16{half_v[15]}}, half_v};
            3'b101:  load_ext = {16'd0, half_v};
            default: load_ext = mem_rdata;
        endcase
        merged = mem_rdata;
        if (size_q == SzByte) begin
            merged[{lane_q, 3'b000} +: 8] = data_q[7:0];
        end else if (lane_q[1]) begin
            merged[31:16] = data_q[15:0];
        end else begin
            merged[15:0] = data_q[15:0];
        end
    end

    always_comb begin
        state_d = state_q;
        waddr_d = waddr_q;
        lane_d  = lane_q;
        size_d  = size_q;
        ctr_d   = ctr_q;
        store_d = store_q;
        misal_d = misal_q;
        data_d  = data_q;
        rdata_d = rdata_q;
        unique case (state_q)
            StIdle: begin
                if (req_read || req_write) begin
                    waddr_d = addr[MEM_AW+1:2];
                    lane_d  = addr[1:0];
                    size_d  = req_size;
                    ctr_d   = MemResultCtr;
                    store_d = req_write;
                    misal_d = req_misal;
                    data_d  = wdata;
                    // Only a completed load may leave data on rdata.
                    if (req_write || req_misal) begin
                        rdata_d = 32'd0;
                    end
                    if (req_misal) begin
                        state_d = StDone;
                    end else if (req_write && (req_size == SzWord)) begin
                        state_d = StWrite;
                    end else begin
                        state_d = StRdIssue;
                    end
                end
            end
            StRdIssue: state_d = StRdWait;
            StRdWait: begin
                if (store_q) begin
                    data_d  = merged;
                    state_d = StWrite;
                end else begin
                    rdata_d = load_ext;
                    state_d = StDone;
                end
            end
            StWrite: state_d = StDone;
            StDone: begin
                misal_d = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            waddr_q <= '0;
            lane_q  <= 2'd0;
            size_q  <= SzByte;
            ctr_q   <= 3'd0;
            store_q <= 1'b0;
            misal_q <= 1'b0;
            data_q  <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            waddr_q <= waddr_d;
            lane_q  <= lane_d;
            size_q  <= size_d;
            ctr_q   <= ctr_d;
            store_q <= store_d;
            misal_q <= misal_d;
            data_q  <= data_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        stall      = ((state_q == StIdle) && (req_read || req_write)) ||
                     (state_q == StRdIssue) || (state_q == StRdWait) || (state_q == StWrite);
        done       = (state_q == StDone);
        misaligned = done && misal_q;
        rdata      = rdata_q;
        // Gated by rst_n so an access interrupted by reset never touches the RAM.
        mem_en     = rst_n && ((state_q == StRdIssue) || (state_q == StWrite));
        mem_we     = rst_n && (state_q == StWrite);
        mem_addr   = waddr_q;
        mem_wdata  = data_q;
    end

endmodule
